// File: rtl/add_in_fifo.sv
// First-word-fall-through FIFO feeding the add stage; valid/ready on both sides.
// Optional occupancy output enabled by defining ADD_IN_FIFO_LEVEL_EN.
module add_in_fifo #(
    parameter int WIDTH  = 1,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WIDTH-1:0]  s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic              full,
    output logic              empty,
    output logic              ovf_err
`ifdef ADD_IN_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level
`endif
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              push;
    logic              pop;

    assign wr_idx = wr_ptr[ADDR_W-1:0];
    assign rd_idx = rd_ptr[ADDR_W-1:0];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr == rd_ptr);

    assign s_ready = ~full;
    assign m_valid = ~empty;
    assign m_data  = m_valid ? mem[rd_idx] : '0;

    assign push = s_valid & ~full;
    assign pop  = m_valid & m_ready;

`ifdef ADD_IN_FIFO_LEVEL_EN
    assign level = wr_ptr - rd_ptr;
`endif

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_idx] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (s_valid && full) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_add_in_fifo.sv
// Directed self-checking bench for add_in_fifo: a WIDTH=1 and a WIDTH=8 instance.
// Expected values are hand-computed constants.
module tb_add_in_fifo;

    logic       clk;
    logic       rst;

    logic       s_valid1, s_ready1, s_data1, m_valid1, m_ready1, m_data1;
    logic       full1, empty1, ovf_err1;

    logic       s_valid8, s_ready8, m_valid8, m_ready8;
    logic [7:0] s_data8, m_data8;
    logic       full8, empty8, ovf_err8;

`ifdef ADD_IN_FIFO_LEVEL_EN
    logic [2:0] level1, level8;
`endif

    int vectors;
    int miscompares;

    add_in_fifo #(.WIDTH(1), .DEPTH(4), .ADDR_W(2)) u_dut1 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
        .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1),
        .full(full1), .empty(empty1), .ovf_err(ovf_err1)
`ifdef ADD_IN_FIFO_LEVEL_EN
        , .level(level1)
`endif
    );

    add_in_fifo #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u_dut8 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
        .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8),
        .full(full8), .empty(empty8), .ovf_err(ovf_err8)
`ifdef ADD_IN_FIFO_LEVEL_EN
        , .level(level8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the 8-bit instance; optionally checks the head word before the edge.
    task automatic cyc8(input logic sv, input logic [7:0] sd, input logic mr,
                        input logic chk_head, input logic [7:0] exp_head, input string tag);
        s_valid8 = sv;
        s_data8  = sd;
        m_ready8 = mr;
        #1;
        if (chk_head) begin
            chk({tag, "_mv"}, 32'(m_valid8), 32'd1);
            chk({tag, "_md"}, 32'(m_data8), 32'(exp_head));
        end
        tick();
        s_valid8 = 1'b0;
        m_ready8 = 1'b0;
    endtask

    task automatic cyc1(input logic sv, input logic sd, input logic mr);
        s_valid1 = sv;
        s_data1  = sd;
        m_ready1 = mr;
        tick();
        s_valid1 = 1'b0;
        m_ready1 = 1'b0;
    endtask

    task automatic check_level8(input string tag, input logic [2:0] exp);
`ifdef ADD_IN_FIFO_LEVEL_EN
        chk(tag, 32'(level8), 32'(exp));
`endif
    endtask

    logic [3:0] pat1;

    initial begin
        vectors     = 0;
        miscompares = 0;
        s_valid1 = 1'b0; s_data1 = 1'b0; m_ready1 = 1'b0;
        s_valid8 = 1'b0; s_data8 = 8'h00; m_ready8 = 1'b0;

        // 1: reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_empty",   32'(empty1),   32'd1);
        chk("rst_full",    32'(full1),    32'd0);
        chk("rst_s_ready", 32'(s_ready1), 32'd1);
        chk("rst_m_valid", 32'(m_valid1), 32'd0);
        chk("rst_m_data",  32'(m_data1),  32'd0);
        chk("rst_ovf",     32'(ovf_err1), 32'd0);
        chk("rst8_empty",  32'(empty8),   32'd1);
        chk("rst8_m_data", 32'(m_data8),  32'd0);
`ifdef ADD_IN_FIFO_LEVEL_EN
        chk("rst_level",   32'(level1),   32'd0);
`endif

        // 2: WIDTH=1 fill with 1,0,1,1 then drain
        pat1 = 4'b1101;
        cyc1(1'b1, pat1[0], 1'b0);
        chk("w1_latency_mv", 32'(m_valid1), 32'd1);
        chk("w1_latency_md", 32'(m_data1),  32'd1);
        chk("w1_not_full1",  32'(full1),    32'd0);
        for (int i = 1; i < 4; i++) cyc1(1'b1, pat1[i], 1'b0);
        chk("w1_full",    32'(full1),    32'd1);
        chk("w1_s_ready", 32'(s_ready1), 32'd0);
        chk("w1_empty0",  32'(empty1),   32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w1_drain%0d", i), 32'(m_data1), 32'(pat1[i]));
            cyc1(1'b0, 1'b0, 1'b1);
        end
        chk("w1_drained_empty", 32'(empty1),   32'd1);
        chk("w1_drained_mv",    32'(m_valid1), 32'd0);
        chk("w1_no_ovf",        32'(ovf_err1), 32'd0);

        // 3: WIDTH=8 interleaved traffic, write pointer wraps past index 0 twice
        cyc8(1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, "pre");
        cyc8(1'b1, 8'hA1, 1'b0, 1'b1, 8'hA0, "pre_h0");
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'hA0, "pre_p0");
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, "pre_p1");
        chk("pre_empty", 32'(empty8), 32'd1);
        cyc8(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "underflow");
        chk("underflow_empty", 32'(empty8), 32'd1);
        cyc8(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, "t3");
        cyc8(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, "t3");
        cyc8(1'b1, 8'h12, 1'b0, 1'b0, 8'h00, "t3");
        check_level8("t3_level3", 3'd3);
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, "t3_p10");
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'h11, "t3_p11");
        cyc8(1'b1, 8'h13, 1'b1, 1'b1, 8'h12, "t3_p12");
        cyc8(1'b1, 8'h14, 1'b0, 1'b1, 8'h13, "t3_h13");
        cyc8(1'b1, 8'h15, 1'b0, 1'b1, 8'h13, "t3_h13b");
        check_level8("t3_level3b", 3'd3);
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'h13, "t3_p13");
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'h14, "t3_p14");
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'h15, "t3_p15");
        chk("t3_empty", 32'(empty8), 32'd1);
        chk("t3_m_data0", 32'(m_data8), 32'd0);

        // 4: two held, simultaneous push+pop for 5 cycles
        cyc8(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, "t4");
        cyc8(1'b1, 8'h21, 1'b0, 1'b0, 8'h00, "t4");
        for (int i = 0; i < 5; i++) begin
            cyc8(1'b1, 8'(8'h22 + i), 1'b1, 1'b1, 8'(8'h20 + i), $sformatf("t4_sp%0d", i));
            chk($sformatf("t4_full%0d", i),  32'(full8),  32'd0);
            chk($sformatf("t4_empty%0d", i), 32'(empty8), 32'd0);
            check_level8($sformatf("t4_level%0d", i), 3'd2);
        end
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'h25, "t4_p25");
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'h26, "t4_p26");
        chk("t4_empty", 32'(empty8), 32'd1);

        // 5: overflow while full, with a simultaneous pop (no write-through)
        for (int i = 0; i < 4; i++) cyc8(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 8'h00, "t5");
        chk("t5_full",    32'(full8),    32'd1);
        chk("t5_s_ready", 32'(s_ready8), 32'd0);
        chk("t5_ovf0",    32'(ovf_err8), 32'd0);
        check_level8("t5_level4", 3'd4);
        cyc8(1'b1, 8'h99, 1'b1, 1'b1, 8'h30, "t5_ovf_p30");
        chk("t5_ovf1",      32'(ovf_err8), 32'd1);
        chk("t5_not_full",  32'(full8),    32'd0);
        check_level8("t5_level3", 3'd3);
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'h31, "t5_p31");
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'h32, "t5_p32");
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'h33, "t5_p33");
        chk("t5_dropped_empty", 32'(empty8),   32'd1);
        chk("t5_ovf_sticky",    32'(ovf_err8), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_ovf_cleared", 32'(ovf_err8), 32'd0);

        // 6: reset mid-stream with 3 entries; reset beats a concurrent push/pop
        cyc8(1'b1, 8'h40, 1'b0, 1'b0, 8'h00, "t6");
        cyc8(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, "t6");
        cyc8(1'b1, 8'h42, 1'b0, 1'b0, 8'h00, "t6");
        rst = 1'b1;
        cyc8(1'b1, 8'h43, 1'b1, 1'b0, 8'h00, "t6_rst");
        rst = 1'b0;
        chk("t6_empty",   32'(empty8),   32'd1);
        chk("t6_m_valid", 32'(m_valid8), 32'd0);
        chk("t6_m_data",  32'(m_data8),  32'd0);
        check_level8("t6_level0", 3'd0);
        cyc8(1'b1, 8'h50, 1'b0, 1'b0, 8'h00, "t6_post");
        cyc8(1'b0, 8'h00, 1'b1, 1'b1, 8'h50, "t6_p50");
        chk("t6_final_empty", 32'(empty8), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
